// File: rtl/sync_pkg.sv
// Shared types and helpers for the multi-channel synchroniser/filter.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;

  // Per-channel glitch filter state.
  typedef enum logic {
    FLT_IDLE    = 1'b0,
    FLT_PENDING = 1'b1
  } flt_state_e;

  // Filter counter width: enough to hold 0..cycles, never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: flop synchroniser chain, stability filter and optional edge
// detector. Edge outputs exist only when MULTI_BIT_SYNC_EDGE_EN is defined.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int unsigned STAGES        = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
`ifdef MULTI_BIT_SYNC_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  logic [STAGES-1:0] sync_q;
  logic              s;

  // Metastability chain: stage0 captures the raw input, last stage feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign s = sync_q[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign dout = s;
    end else begin : g_filter
      localparam int unsigned CW = unsigned'(cnt_width(int'(FILTER_CYCLES)));
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

      flt_state_e    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          out_q, out_d;
      logic          mismatch;

      assign mismatch = s ^ out_q;

      // Filter state, stability counter and accepted level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= FLT_IDLE;
          cnt_q   <= '0;
          out_q   <= RST_VAL;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          out_q   <= out_d;
        end
      end

      // Accept a new level only after LAST+1 consecutive mismatching samples;
      // any agreeing sample discards the accumulated count.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
          FLT_IDLE: begin
            cnt_d = '0;
            if (mismatch) begin
              if (cnt_q == LAST) begin
                out_d = s;
              end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = FLT_PENDING;
              end
            end
          end
          FLT_PENDING: begin
            if (!mismatch) begin
              cnt_d   = '0;
              state_d = FLT_IDLE;
            end else if (cnt_q == LAST) begin
              out_d   = s;
              cnt_d   = '0;
              state_d = FLT_IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = FLT_IDLE;
          end
        endcase
      end

      assign dout = out_q;
    end
  endgenerate

`ifdef MULTI_BIT_SYNC_EDGE_EN
  logic prev_q;

  // Previous filtered level; reset equal to the output so no pulse follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= dout;
    end
  end

  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;
`endif

endmodule

// File: rtl/multi_bit_sync_filter.sv
// Multi-channel synchroniser with per-channel glitch filter.
// Define MULTI_BIT_SYNC_EDGE_EN to add rise/fall/any_edge pulse outputs.
module multi_bit_sync_filter
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
`ifdef MULTI_BIT_SYNC_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
`endif
);

  // Too short a chain gives no metastability protection; refuse to build.
  generate
    if (STAGES < SYNC_MIN_STAGES) begin : g_stage_check
      $fatal(1, "multi_bit_sync_filter: STAGES must be >= %0d", SYNC_MIN_STAGES);
    end
  endgenerate

  // Independent channel instances.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RST_VAL       (RESET_VAL[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (async_in[i]),
      .dout  (sync_out[i])
`ifdef MULTI_BIT_SYNC_EDGE_EN
      ,
      .rise  (rise[i]),
      .fall  (fall[i])
`endif
    );
  end

`ifdef MULTI_BIT_SYNC_EDGE_EN
  assign any_edge = |(rise | fall);
`endif

endmodule

// File: doc/multi_bit_sync_filter.md
# multi_bit_sync_filter

Parametrised multi-channel synchroniser for asynchronous level inputs (buttons, status lines, strobes from foreign domains) entering the single system clock domain. Each channel passes through a configurable-depth flip-flop chain, then a per-channel glitch filter that only accepts a new level after it has been stable for a programmable number of cycles. Optional per-channel rise/fall pulse outputs feed event-driven logic directly. It supersedes the fixed single-bit chain wherever more than one line, deeper metastability protection or noise rejection is needed.

## Interface
- `WIDTH`, 4: number of independent channels (≥1)
- `STAGES`, 2: synchroniser flops per channel (≥2)
- `FILTER_CYCLES`, 4: consecutive stable cycles required before the filtered output changes; 0 = filter bypassed
- `RESET_VAL`, {WIDTH{1'b0}}: per-channel reset level for all sync flops, filtered outputs and edge history

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `async_in`  in  WIDTH  asynchronous level inputs
- `sync_out`  out  WIDTH  synchronised, filtered levels
- `rise`  out  WIDTH  one-cycle pulse on 0→1 of `sync_out` (only with macro)
- `fall`  out  WIDTH  one-cycle pulse on 1→0 of `sync_out` (only with macro)
- `any_edge`  out  1  OR of all `rise|fall` (only with macro)

## Operation
- Reset (`rst_n`=0, asynchronous): every sync flop, `sync_out`, and edge history = `RESET_VAL`; filter counters = 0; `rise`/`fall`/`any_edge` = 0.
- Sync chain per channel: stage0 ← `async_in[i]`, stage k ← stage k-1; `s[i]` = last stage.
- Filter, per channel, counter width `$clog2(FILTER_CYCLES+1)`:
  - IDLE (`s[i]` == `sync_out[i]`): counter ← 0.
  - PENDING (`s[i]` != `sync_out[i]`): counter increments each cycle; when counter == `FILTER_CYCLES-1` and mismatch persists, `sync_out[i]` ← `s[i]`, counter ← 0.
  - Any cycle of agreement during PENDING returns to IDLE with counter ← 0 (glitch rejected; no partial credit).
  - Counter never exceeds `FILTER_CYCLES-1`; no wrap.
- `FILTER_CYCLES`=0: no counters; `sync_out[i]` = `s[i]` directly.
- Edge detect: `prev` register ← `sync_out` each cycle; `rise` = `sync_out & ~prev`, `fall` = `~sync_out & prev`. Combinational from registers, glitch-free.
- Channels fully independent; simultaneous changes on several channels each produce their own pulses in the same cycle.

## Timing
- Input changes before edge E1 (captured by stage0 at E1): `s` changes after edge E`STAGES`.
- `sync_out` changes after edge E(`STAGES`+`FILTER_CYCLES`); with defaults, after E6.
- `rise`/`fall` high for exactly the one cycle in which `sync_out` first shows the new level; low the next cycle.
- Pulses of `async_in` shorter than `FILTER_CYCLES` clk periods at the sync output never reach `sync_out`.
- Reset de-assertion mid-operation: all channels restart from `RESET_VAL`; no edge pulse on the first post-reset cycle, even if `async_in` ≠ `RESET_VAL` (pulse appears only when the filter later accepts the new level).

## Configuration
- `MULTI_BIT_SYNC_EDGE_EN` defined: `prev` register, `rise`, `fall`, `any_edge` present as above.
- Not defined: these ports and `prev` are absent; only `sync_out` remains. Sync and filter behaviour are unchanged.

## Structure
- Package `sync_pkg`: `SYNC_MIN_STAGES`=2, `function cnt_width(int cycles)` returning `$clog2(cycles+1)` (min 1), channel state enum `{FLT_IDLE, FLT_PENDING}`.
- Sub-module `sync_filter_chan`: one channel's sync chain + filter counter + edge logic; top instantiates `WIDTH` copies in a generate loop and ORs edges into `any_edge`.
- Elaboration-time check: `STAGES` < 2 is a fatal error.

## Test plan
- Reset: `RESET_VAL`=4'b0101, hold `rst_n`=0, drive `async_in`=4'b1010 → `sync_out`=4'b0101, `rise`=`fall`=0; release → `sync_out`=4'b1010 after E6, `rise`=4'b1010, `fall`=4'b0101 for one cycle.
- Latency: defaults, `async_in[0]` 0→1 before E1 → `sync_out[0]` rises after E6, `rise[0]` high exactly one cycle, `any_edge`=1 same cycle.
- Glitch: `async_in[2]`=1 for 3 cycles then 0 → `sync_out[2]` stays 0, no pulses; 4 cycles → accepted.
- Bypass: `FILTER_CYCLES`=0, `STAGES`=3 → `sync_out` follows input after E3, 1-cycle input pulse propagates.
- Simultaneous: all four channels toggle together → `rise`=4'hF in one cycle; reassert `rst_n` mid-PENDING → counters cleared, outputs back to `RESET_VAL`.
- Macro off: compile without `MULTI_BIT_SYNC_EDGE_EN` → build has no `rise`/`fall`/`any_edge`; latency tests above still pass on `sync_out`.
